// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch bus responder: grants core fetches after a fixed number of wait
// states, reads a synchronous instruction memory and returns data or an error one cycle later.
module ibex_instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES  = 4096,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned MEM_AW     = $clog2(SIZE_BYTES / 4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [31:0]       instr_addr,
  output logic              instr_gnt,
  output logic              instr_rvalid,
  output logic              instr_err,
  output logic [31:0]       instr_rdata,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              stat_clr,
  output logic [31:0]       fetch_count,
  output logic [15:0]       err_count,
  output logic [31:0]       last_err_addr
);

  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);
  localparam logic [31:0] SIZE_W    = 32'(SIZE_BYTES);

  logic [2:0]  wcnt_q, wcnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] last_err_addr_q, last_err_addr_d;

  logic [31:0] offset_s;
  logic        addr_ok_s;
  logic        gnt_s;
  logic        mem_req_s;
  logic        bad_gnt_s;

  // Address decode and grant; an address below BASE wraps to a huge offset and fails the bound.
  always_comb begin
    offset_s  = instr_addr - BASE_ADDR;
    addr_ok_s = (offset_s < SIZE_W) && (instr_addr[1:0] == 2'b00);
    gnt_s     = rst_n && instr_req && (wcnt_q == 3'd0);
    mem_req_s = gnt_s && addr_ok_s;
    bad_gnt_s = gnt_s && !addr_ok_s;
  end

  // Wait-state counter and one-deep response register.
  always_comb begin
    wcnt_d   = wcnt_q;
    rvalid_d = gnt_s;
    err_d    = bad_gnt_s;
    if (!instr_req || gnt_s) begin
      wcnt_d = WAIT_INIT;
    end else if (wcnt_q != 3'd0) begin
      wcnt_d = wcnt_q - 3'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Debug statistics; a clear in the same cycle as a grant takes priority.
  always_comb begin
    fetch_count_d   = fetch_count_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;
    if (stat_clr) begin
      fetch_count_d   = 32'h0;
      err_count_d     = 16'h0;
      last_err_addr_d = 32'h0;
    end else begin
      if (mem_req_s) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        fetch_count_d = fetch_count_q;
      end
      if (bad_gnt_s) begin
        last_err_addr_d = instr_addr;
        if (err_count_q != 16'hFFFF) begin
          err_count_d = err_count_q + 16'd1;
        end else begin
          err_count_d = err_count_q;
        end
      end else begin
        last_err_addr_d = last_err_addr_q;
        err_count_d     = err_count_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q          <= WAIT_INIT;
      rvalid_q        <= 1'b0;
      err_q           <= 1'b0;
      fetch_count_q   <= 32'h0;
      err_count_q     <= 16'h0;
      last_err_addr_q <= 32'h0;
    end else begin
      wcnt_q          <= wcnt_d;
      rvalid_q        <= rvalid_d;
      err_q           <= err_d;
      fetch_count_q   <= fetch_count_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign instr_gnt     = gnt_s;
  assign instr_rvalid  = rvalid_q;
  assign instr_err     = err_q;
  assign instr_rdata   = (rvalid_q && !err_q) ? mem_rdata : 32'h0;
  assign mem_req       = mem_req_s;
  assign mem_addr      = mem_req_s ? offset_s[MEM_AW+1:2] : {MEM_AW{1'b0}};
  assign fetch_count   = fetch_count_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Scoreboard bench for ibex_instr_mem_responder: three instances with 0, 2 and 3 wait
// states driven by directed fetches; a negedge monitor checks every response.
module tb_ibex_instr_mem_responder;

  typedef struct packed {
    logic [1:0]  idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req    [3];
  logic [31:0] addr   [3];
  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [31:0] rdata  [3];
  logic        mreq   [3];
  logic [9:0]  maddr  [3];
  logic [31:0] mrdata [3];
  logic        sclr   [3];
  logic [31:0] fcnt   [3];
  logic [15:0] ecnt   [3];
  logic [31:0] lea    [3];

  logic        gnt_prev [3];
  logic        mon_en;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total;
  int          bad;

  ibex_instr_mem_responder #(.BASE_ADDR(32'h0), .SIZE_BYTES(4096), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .instr_req(req[0]), .instr_addr(addr[0]), .instr_gnt(gnt[0]),
    .instr_rvalid(rvalid[0]), .instr_err(err[0]), .instr_rdata(rdata[0]), .mem_req(mreq[0]),
    .mem_addr(maddr[0]), .mem_rdata(mrdata[0]), .stat_clr(sclr[0]), .fetch_count(fcnt[0]),
    .err_count(ecnt[0]), .last_err_addr(lea[0]));

  ibex_instr_mem_responder #(.BASE_ADDR(32'h0), .SIZE_BYTES(4096), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .instr_req(req[1]), .instr_addr(addr[1]), .instr_gnt(gnt[1]),
    .instr_rvalid(rvalid[1]), .instr_err(err[1]), .instr_rdata(rdata[1]), .mem_req(mreq[1]),
    .mem_addr(maddr[1]), .mem_rdata(mrdata[1]), .stat_clr(sclr[1]), .fetch_count(fcnt[1]),
    .err_count(ecnt[1]), .last_err_addr(lea[1]));

  ibex_instr_mem_responder #(.BASE_ADDR(32'h0), .SIZE_BYTES(4096), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .instr_req(req[2]), .instr_addr(addr[2]), .instr_gnt(gnt[2]),
    .instr_rvalid(rvalid[2]), .instr_err(err[2]), .instr_rdata(rdata[2]), .mem_req(mreq[2]),
    .mem_addr(maddr[2]), .mem_rdata(mrdata[2]), .stat_clr(sclr[2]), .fetch_count(fcnt[2]),
    .err_count(ecnt[2]), .last_err_addr(lea[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word n holds 0xA000_0000 | n; an idle memory returns junk to expose ungated rdata.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mrdata[i] <= mreq[i] ? (32'hA000_0000 | {22'h0, maddr[i]}) : 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, idx, act, want, $time);
    end
  endtask

  // Response monitor: rvalid must follow each grant by one cycle and match the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("rvalid_lat", i, 32'(rvalid[i]), 32'(gnt_prev[i]));
        if (rvalid[i]) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", i, 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            chk("resp_idx", i, 32'(mon_e.idx), 32'(i));
            chk("resp_err", i, 32'(err[i]), 32'(mon_e.err));
            chk("resp_rdata", i, rdata[i], mon_e.rdata);
          end
        end else begin
          chk("rdata_idle", i, rdata[i], 32'h0);
        end
        if (!mreq[i]) begin
          chk("maddr_idle", i, 32'(maddr[i]), 32'h0);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      gnt_prev[i] <= gnt[i];
    end
  end

  // Present one fetch (starting just after a posedge), check grant latency and memory strobe.
  task automatic fetch(input int i, input logic [31:0] a, input int wt, input logic e,
                       input logic [31:0] rd, input logic [9:0] ma, input bit hold);
    int   cyc;
    bit   done;
    exp_t x;
    req[i]  = 1'b1;
    addr[i] = a;
    cyc     = 0;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (gnt[i]) begin
        chk("gnt_lat", i, 32'(cyc), 32'(wt));
        chk("mem_req", i, 32'(mreq[i]), 32'(!e));
        chk("mem_addr", i, 32'(maddr[i]), 32'(ma));
        x.idx   = 2'(i);
        x.err   = e;
        x.rdata = rd;
        exp_q.push_back(x);
        done = 1'b1;
      end else if (cyc >= 20) begin
        chk("gnt_timeout", i, 32'(cyc), 32'(wt));
        done = 1'b1;
      end else begin
        cyc++;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) req[i] = 1'b0;
  endtask

  task automatic stats(input string nm, input int i, input logic [31:0] f, input logic [15:0] ec,
                       input logic [31:0] la);
    chk({nm, "_fcnt"}, i, fcnt[i], f);
    chk({nm, "_ecnt"}, i, 32'(ecnt[i]), 32'(ec));
    chk({nm, "_lea"}, i, lea[i], la);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      addr[i] = 32'h0;
      sclr[i] = 1'b0;
    end
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_gnt", i, 32'(gnt[i]), 32'd0);
      chk("rst_rvalid", i, 32'(rvalid[i]), 32'd0);
      chk("rst_err", i, 32'(err[i]), 32'd0);
      chk("rst_rdata", i, rdata[i], 32'h0);
      chk("rst_mreq", i, 32'(mreq[i]), 32'd0);
      chk("rst_maddr", i, 32'(maddr[i]), 32'd0);
      stats("rst", i, 32'h0, 16'h0, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    req[0] = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Zero wait states, request held: one fetch per cycle.
    fetch(0, 32'h0, 0, 1'b0, 32'hA000_0000, 10'd0, 1'b1);
    fetch(0, 32'h4, 0, 1'b0, 32'hA000_0001, 10'd1, 1'b1);
    fetch(0, 32'h8, 0, 1'b0, 32'hA000_0002, 10'd2, 1'b0);
    @(negedge clk);
    stats("seq3", 0, 32'd3, 16'd0, 32'h0);
    @(posedge clk);
    #1;

    // Out-of-window and misaligned addresses.
    fetch(0, 32'h1000, 0, 1'b1, 32'h0, 10'd0, 1'b1);
    fetch(0, 32'h2, 0, 1'b1, 32'h0, 10'd0, 1'b0);
    @(negedge clk);
    stats("err2", 0, 32'd3, 16'd2, 32'h2);
    @(posedge clk);
    #1;

    // Clear coincident with an error grant, then with a good grant.
    sclr[0] = 1'b1;
    fetch(0, 32'h0000_0FFE, 0, 1'b1, 32'h0, 10'd0, 1'b0);
    sclr[0] = 1'b0;
    @(negedge clk);
    stats("clr_err", 0, 32'd0, 16'd0, 32'h0);
    @(posedge clk);
    #1;
    fetch(0, 32'hFFC, 0, 1'b0, 32'hA000_03FF, 10'd1023, 1'b0);
    @(negedge clk);
    stats("after_clr", 0, 32'd1, 16'd0, 32'h0);
    @(posedge clk);
    #1;
    sclr[0] = 1'b1;
    fetch(0, 32'h10, 0, 1'b0, 32'hA000_0004, 10'd4, 1'b0);
    sclr[0] = 1'b0;
    @(negedge clk);
    stats("clr_fetch", 0, 32'd0, 16'd0, 32'h0);
    @(posedge clk);
    #1;

    // Saturate the error counter, then push two more errors past the maximum.
    for (int k = 0; k < 65535; k++) begin
      fetch(0, 32'h2, 0, 1'b1, 32'h0, 10'd0, k != 65534);
    end
    @(negedge clk);
    stats("sat_max", 0, 32'd0, 16'hFFFF, 32'h2);
    @(posedge clk);
    #1;
    fetch(0, 32'h2, 0, 1'b1, 32'h0, 10'd0, 1'b1);
    fetch(0, 32'hFFFF_FFFC, 0, 1'b1, 32'h0, 10'd0, 1'b0);
    @(negedge clk);
    stats("sat_hold", 0, 32'd0, 16'hFFFF, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;

    // Two wait states, back-to-back with request held.
    fetch(1, 32'h10, 2, 1'b0, 32'hA000_0004, 10'd4, 1'b1);
    fetch(1, 32'h14, 2, 1'b0, 32'hA000_0005, 10'd5, 1'b0);
    @(negedge clk);
    stats("ws2", 1, 32'd2, 16'd0, 32'h0);
    @(posedge clk);
    #1;

    // Three wait states, request abandoned after one cycle and then reissued.
    req[2]  = 1'b1;
    addr[2] = 32'h0;
    @(negedge clk);
    chk("drop_gnt", 2, 32'(gnt[2]), 32'd0);
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(posedge clk);
    #1;
    fetch(2, 32'h8, 3, 1'b0, 32'hA000_0002, 10'd2, 1'b0);
    @(negedge clk);
    stats("ws3", 2, 32'd1, 16'd0, 32'h0);
    @(posedge clk);
    #1;

    // Reset pulse in what would be the grant cycle; the fetch then restarts cold.
    req[1]  = 1'b1;
    addr[1] = 32'h20;
    @(negedge clk);
    chk("pre_rst_wait", 1, 32'(gnt[1]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_wait", 1, 32'(gnt[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("gnt_in_rst", 1, 32'(gnt[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch(1, 32'h20, 2, 1'b0, 32'hA000_0008, 10'd8, 1'b0);
    @(negedge clk);
    stats("post_rst", 1, 32'd1, 16'd0, 32'h0);
    stats("post_rst", 0, 32'd0, 16'd0, 32'h0);
    stats("post_rst", 2, 32'd0, 16'd0, 32'h0);

    repeat (3) @(negedge clk);
    chk("queue_drain", 0, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
